// File: rtl/bp_me_io_load_arbiter.sv
// Round-robin arbiter that shares one IO command/response link among several loaders.
// Responses come back in order and are steered to the requester recorded in a source-ID FIFO.
module bp_me_io_load_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [num_req_p-1:0][msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                  req_cmd_v_i,
    output logic [num_req_p-1:0]                  req_cmd_yumi_o,

    output logic [msg_width_p-1:0]                req_resp_o,
    output logic [num_req_p-1:0]                  req_resp_v_o,
    input  logic [num_req_p-1:0]                  req_resp_ready_i,

    output logic [msg_width_p-1:0]                io_cmd_o,
    output logic                                  io_cmd_v_o,
    input  logic                                  io_cmd_ready_i,

    input  logic [msg_width_p-1:0]                io_resp_i,
    input  logic                                  io_resp_v_i,
    output logic                                  io_resp_yumi_o,

    output logic                                  idle_o,
    output logic                                  error_o
);

    localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp = ((max_outstanding_p + 1) > 1) ? $clog2(max_outstanding_p + 1) : 1;

    localparam logic [id_w_lp-1:0]  last_req_lp  = id_w_lp'(num_req_p - 1);
    localparam logic [ptr_w_lp-1:0] last_slot_lp = ptr_w_lp'(max_outstanding_p - 1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp   = cnt_w_lp'(max_outstanding_p);

    logic [id_w_lp-1:0]  rr_ptr_r;
    logic [id_w_lp-1:0]  grant_id;
    logic [id_w_lp-1:0]  scan_id;
    logic                grant_found;

    logic [id_w_lp-1:0]  src_mem_r [max_outstanding_p];
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic [id_w_lp-1:0]  src_id;

    logic                outstanding;
    logic                not_full;
    logic                push;
    logic                pop;

    // Scan from the priority pointer upward (wrapping); the first valid requester wins.
    always_comb begin
        grant_id    = rr_ptr_r;
        grant_found = 1'b0;
        scan_id     = rr_ptr_r;
        for (int i = 0; i < num_req_p; i++) begin
            if (!grant_found && req_cmd_v_i[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
            scan_id = (scan_id == last_req_lp) ? '0 : scan_id + 1'b1;
        end
    end

    // Handshakes: a command moves when io_cmd_v_o & io_cmd_ready_i (valid never looks at ready);
    // a response is consumed when io_resp_v_i & io_resp_yumi_o.
    assign outstanding = (count_r != '0);
    assign not_full    = (count_r < max_cnt_lp);
    assign src_id      = src_mem_r[rd_ptr_r];

    assign io_cmd_v_o  = ~reset_i & grant_found & not_full;
    assign io_cmd_o    = reset_i ? '0 : req_cmd_i[grant_id];
    assign push        = io_cmd_v_o & io_cmd_ready_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        if (push) begin
            req_cmd_yumi_o[grant_id] = 1'b1;
        end
    end

    // With nothing outstanding a response has no owner: it is dropped and flagged.
    always_comb begin
        req_resp_v_o   = '0;
        io_resp_yumi_o = 1'b0;
        error_o        = 1'b0;
        if (!reset_i && io_resp_v_i) begin
            if (outstanding) begin
                req_resp_v_o[src_id] = 1'b1;
                io_resp_yumi_o       = req_resp_ready_i[src_id];
            end else begin
                io_resp_yumi_o = 1'b1;
                error_o        = 1'b1;
            end
        end
    end

    assign req_resp_o = reset_i ? '0 : io_resp_i;
    assign pop        = io_resp_yumi_o & outstanding;
    assign idle_o     = reset_i | ~outstanding;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                rr_ptr_r <= (grant_id == last_req_lp) ? '0 : grant_id + 1'b1;
                wr_ptr_r <= (wr_ptr_r == last_slot_lp) ? '0 : wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == last_slot_lp) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_r and the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem_r[wr_ptr_r] <= grant_id;
        end
    end

endmodule

// File: tb/tb_bp_me_io_load_arbiter.sv
// Bench for bp_me_io_load_arbiter: directed scenarios followed by random traffic,
// checked against a small round-robin / in-order reference model and payload scoreboards.
module tb_bp_me_io_load_arbiter;

    localparam int N = 2;
    localparam int W = 16;
    localparam int M = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0][W-1:0] req_cmd;
    logic [N-1:0]      req_cmd_v;
    logic [N-1:0]      req_cmd_yumi;
    logic [W-1:0]      req_resp;
    logic [N-1:0]      req_resp_v;
    logic [N-1:0]      req_resp_ready;
    logic [W-1:0]      io_cmd;
    logic              io_cmd_v;
    logic              io_cmd_ready;
    logic [W-1:0]      io_resp;
    logic              io_resp_v;
    logic              io_resp_yumi;
    logic              idle;
    logic              error;

    bp_me_io_load_arbiter #(
        .num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_yumi_o(req_cmd_yumi),
        .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_ready_i(req_resp_ready),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_cmd_ready),
        .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_resp_yumi),
        .idle_o(idle), .error_o(error)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // scoreboards
    logic [W-1:0]   exp_q[$];
    logic [W+1:0]   resp_q[$];

    // reference model
    logic           m_ptr;
    logic           m_src[$];

    always @(negedge clk) begin
        if (!reset && (req_cmd_yumi != '0)) begin
            if (exp_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
            else check("cmd_payload", 32'(io_cmd), 32'(exp_q.pop_front()));
        end
        if (!reset && io_resp_yumi && (req_resp_v != '0)) begin
            if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
            else check("resp_delivery", 32'({req_resp_v, req_resp}), 32'(resp_q.pop_front()));
        end
    end

    task automatic do_reset(input int cycles);
        reset          = 1'b1;
        req_cmd_v      = 2'b11;
        req_cmd[0]     = 16'h1234;
        req_cmd[1]     = 16'h5678;
        io_cmd_ready   = 1'b1;
        io_resp_v      = 1'b1;
        io_resp        = 16'hbeef;
        req_resp_ready = 2'b11;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_io_cmd_v", 32'(io_cmd_v), 32'd0);
            check("rst_cmd_yumi", 32'(req_cmd_yumi), 32'd0);
            check("rst_resp_v", 32'(req_resp_v), 32'd0);
            check("rst_resp_yumi", 32'(io_resp_yumi), 32'd0);
            check("rst_error", 32'(error), 32'd0);
            check("rst_idle", 32'(idle), 32'd1);
            check("rst_io_cmd", 32'(io_cmd), 32'd0);
            check("rst_resp_data", 32'(req_resp), 32'd0);
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        req_cmd_v = 2'b00;
        io_resp_v = 1'b0;
        m_ptr     = 1'b0;
        m_src.delete();
    endtask

    // One clock of stimulus: drive inputs, derive expectations from the model, check, advance.
    task automatic cycle(input logic [1:0] v, input logic cready, input logic rv,
                         input logic [1:0] rready, input logic keep_resp);
        logic       g;
        logic       src;
        logic       exp_cmd_v;
        logic [1:0] exp_yumi;
        logic [1:0] exp_rv;
        logic       exp_ryumi;
        logic       exp_err;
        logic       exp_idle;

        req_cmd[0] = 16'($urandom);
        req_cmd[1] = 16'($urandom);
        if (!keep_resp) io_resp = 16'($urandom);
        req_cmd_v      = v;
        io_cmd_ready   = cready;
        io_resp_v      = rv;
        req_resp_ready = rready;

        g         = v[m_ptr] ? m_ptr : ~m_ptr;
        exp_cmd_v = (v != 2'b00) && (m_src.size() < M);
        exp_yumi  = (exp_cmd_v && cready) ? (2'b01 << g) : 2'b00;
        exp_idle  = (m_src.size() == 0);
        exp_rv    = 2'b00;
        exp_ryumi = 1'b0;
        exp_err   = 1'b0;
        src       = 1'b0;
        if (rv) begin
            if (m_src.size() > 0) begin
                src       = m_src[0];
                exp_rv    = 2'b01 << src;
                exp_ryumi = rready[src];
            end else begin
                exp_ryumi = 1'b1;
                exp_err   = 1'b1;
            end
        end
        if (exp_yumi != 2'b00) exp_q.push_back(req_cmd[g]);
        if (exp_ryumi && (exp_rv != 2'b00)) resp_q.push_back({exp_rv, io_resp});

        @(negedge clk);
        check("io_cmd_v", 32'(io_cmd_v), 32'(exp_cmd_v));
        check("cmd_yumi", 32'(req_cmd_yumi), 32'(exp_yumi));
        check("resp_v", 32'(req_resp_v), 32'(exp_rv));
        check("resp_yumi", 32'(io_resp_yumi), 32'(exp_ryumi));
        check("error", 32'(error), 32'(exp_err));
        check("idle", 32'(idle), 32'(exp_idle));
        if (exp_rv != 2'b00) check("resp_data", 32'(req_resp), 32'(io_resp));

        if (exp_ryumi && (exp_rv != 2'b00)) void'(m_src.pop_front());
        if (exp_yumi != 2'b00) begin
            m_src.push_back(g);
            m_ptr = ~g;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset(2);

        // both requesters streaming: alternate grants until four are outstanding
        for (int i = 0; i < 4; i++) cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);

        // build sources 0,1,1,0 and return them, stalling the first src=1 for three cycles
        cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b01, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 2'b01, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);

        // full: a pop in the same cycle must not admit a push
        for (int i = 0; i < 4; i++) cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b01, 1'b1, 1'b1, 2'b11, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);

        // stray response while idle, then error must drop again
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b0, 2'b11, 1'b0);

        // requester 1 withdraws before the link accepts; requester 0 then goes through
        cycle(2'b10, 1'b0, 1'b0, 2'b11, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 2'b11, 1'b0);

        // reset with three outstanding, pointer left at 1
        cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
        do_reset(1);
        cycle(2'b11, 1'b1, 1'b1, 2'b11, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 2'b11, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        end

        check("cmd_q_drained", 32'(exp_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
